// File: rtl/encode_4to2_debounced_pkg.sv
// Shared types and helpers for the debounced 4-to-2 encoder.
package encode_pkg;

  typedef logic [1:0] code_t;

  localparam code_t CODE0 = 2'd0;
  localparam code_t CODE1 = 2'd1;
  localparam code_t CODE2 = 2'd2;
  localparam code_t CODE3 = 2'd3;

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_e;

  typedef struct packed {
    code_t code;
    logic  valid;
    logic  multi;
  } enc_rsp_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Highest set bit wins; exact index for a one-hot pattern.
  function automatic code_t enc_index(input logic [3:0] v);
    if (v[3])      return CODE3;
    else if (v[2]) return CODE2;
    else if (v[1]) return CODE1;
    else           return CODE0;
  endfunction

endpackage

// File: rtl/encode_4to2_debounced_if.sv
// Input bus plus Valid/Ready result channel of the debounced encoder.
interface encode_4to2_debounced_if;
  import encode_pkg::*;

  logic [3:0] In;
  logic       Ready;
  code_t      Out;
  logic       Valid;
  logic       Multi;

  modport master (output In, output Ready, input Out, input Valid, input Multi);
  modport slave  (input In, input Ready, output Out, output Valid, output Multi);
endinterface

// File: rtl/encode_4to2_debounced_debounce.sv
// debounce_4: samples the raw bus and flags when it has held for DEBOUNCE_CYCLES samples.
module debounce_4 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] In,
  output logic [3:0] S,
  output logic       Stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s_d   = In;
    cnt_d = cnt_q;
    if (In != s_q)          cnt_d = '0;
    else if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign S      = s_q;
  assign Stable = (cnt_q == CMAX);
endmodule

// File: rtl/encode_4to2_debounced.sv
// Debounced 4-to-2 encoder: one Valid/Ready transfer per stable press, re-armed on stable release.
// ENC_PRIORITY_EN: report multi-hot patterns by priority instead of rejecting them.
module encode_4to2_debounced
  import encode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  encode_4to2_debounced_if.slave  bus
);
  logic [3:0] s;
  logic       stable;

  debounce_4 #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .Clk    (Clk),
    .Rst    (Rst),
    .In     (bus.In),
    .S      (s),
    .Stable (stable)
  );

  state_e   state_q, state_d;
  enc_rsp_t rsp_q, rsp_d;

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (stable && s != 4'd0) begin
          if (is_onehot(s)) begin
            rsp_d   = '{code: enc_index(s), valid: 1'b1, multi: 1'b0};
            state_d = HOLD;
          end else begin
`ifdef ENC_PRIORITY_EN
            rsp_d   = '{code: enc_index(s), valid: 1'b1, multi: 1'b1};
            state_d = HOLD;
`else
            // Rejected: Out keeps its old code, Multi pulses for the one RELEASE-entry cycle.
            rsp_d.multi = 1'b1;
            state_d     = RELEASE;
`endif
          end
        end
      end
      HOLD: begin
        if (rsp_q.valid && bus.Ready) begin
          rsp_d.valid = 1'b0;
          rsp_d.multi = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        rsp_d.multi = 1'b0;
        if (stable && s == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.Out   = rsp_q.code;
  assign bus.Valid = rsp_q.valid;
  assign bus.Multi = rsp_q.multi;
endmodule

// File: tb/tb_encode_4to2_debounced.sv
// Directed bench for encode_4to2_debounced with DEBOUNCE_CYCLES = 4.
module tb_encode_4to2_debounced;
  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  encode_4to2_debounced_if bus ();

  encode_4to2_debounced #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    bus.In = 4'd0; Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.In = 4'b0100; bus.Ready = 1'b0; Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, bus.Valid); end
      checks++; if (bus.Out !== 2'd0) begin errors++; $display("FAIL reset_out cyc%0d got %0d exp 0", i, bus.Out); end
      checks++; if (bus.Multi !== 1'b0) begin errors++; $display("FAIL reset_multi cyc%0d got %b exp 0", i, bus.Multi); end
    end
    Rst = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    bus.Ready = 1'b1; bus.In = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL press_early_valid edge%0d got %b exp 0", i, bus.Valid); end
    end
    tick();
    checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL press_valid_edge5 got %b exp 1", bus.Valid); end
    checks++; if (bus.Out !== 2'd2) begin errors++; $display("FAIL press_out got %0d exp 2", bus.Out); end
    checks++; if (bus.Multi !== 1'b0) begin errors++; $display("FAIL press_multi got %b exp 0", bus.Multi); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL press_held_valid cyc%0d got %b exp 0", i, bus.Valid); end
    end
    bus.In = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL release_valid cyc%0d got %b exp 0", i, bus.Valid); end
    end
    bus.In = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL repress_early_valid edge%0d got %b exp 0", i, bus.Valid); end
    end
    tick();
    checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL repress_valid got %b exp 1", bus.Valid); end
    checks++; if (bus.Out !== 2'd0) begin errors++; $display("FAIL repress_out got %0d exp 0", bus.Out); end
    tick();
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL repress_drop got %b exp 0", bus.Valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.Ready = 1'b0; bus.In = 4'b1000;
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b exp 1", i, bus.Valid); end
      checks++; if (bus.Out !== 2'd3) begin errors++; $display("FAIL bp_out cyc%0d got %0d exp 3", i, bus.Out); end
      if (i == 3) bus.In = 4'b0001;
      tick();
    end
    bus.Ready = 1'b1;
    tick();
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL bp_complete got %b exp 0", bus.Valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL bp_no_rereport cyc%0d got %b exp 0", i, bus.Valid); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.Ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.In = ((i / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL glitch_valid cyc%0d got %b exp 0", i, bus.Valid); end
    end
  endtask

  task automatic test_multi();
    do_reset();
    bus.Ready = 1'b0; bus.In = 4'b0110;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.Multi !== 1'b0) begin errors++; $display("FAIL multi_early edge%0d got %b exp 0", i, bus.Multi); end
    end
    tick();
`ifdef ENC_PRIORITY_EN
    checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL multi_prio_valid got %b exp 1", bus.Valid); end
    checks++; if (bus.Out !== 2'd2) begin errors++; $display("FAIL multi_prio_out got %0d exp 2", bus.Out); end
    checks++; if (bus.Multi !== 1'b1) begin errors++; $display("FAIL multi_prio_flag got %b exp 1", bus.Multi); end
    bus.Ready = 1'b1;
    tick();
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL multi_prio_drop got %b exp 0", bus.Valid); end
    checks++; if (bus.Multi !== 1'b0) begin errors++; $display("FAIL multi_prio_clear got %b exp 0", bus.Multi); end
`else
    checks++; if (bus.Multi !== 1'b1) begin errors++; $display("FAIL multi_pulse got %b exp 1", bus.Multi); end
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL multi_rej_valid got %b exp 0", bus.Valid); end
    checks++; if (bus.Out !== 2'd0) begin errors++; $display("FAIL multi_rej_out got %0d exp 0", bus.Out); end
    tick();
    checks++; if (bus.Multi !== 1'b0) begin errors++; $display("FAIL multi_pulse_end got %b exp 0", bus.Multi); end
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL multi_rej_valid2 got %b exp 0", bus.Valid); end
`endif
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus.Ready = 1'b0; bus.In = 4'b0100;
    repeat (5) tick();
    checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL midrst_hold got %b exp 1", bus.Valid); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.Valid); end
    checks++; if (bus.Out !== 2'd0) begin errors++; $display("FAIL midrst_out got %0d exp 0", bus.Out); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL midrst_early edge%0d got %b exp 0", i, bus.Valid); end
    end
    tick();
    checks++; if (bus.Valid !== 1'b1) begin errors++; $display("FAIL midrst_fresh_valid got %b exp 1", bus.Valid); end
    checks++; if (bus.Out !== 2'd2) begin errors++; $display("FAIL midrst_fresh_out got %0d exp 2", bus.Out); end
    bus.Ready = 1'b1;
    tick();
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL midrst_fresh_drop got %b exp 0", bus.Valid); end
  endtask

  initial begin
    Rst = 1'b1; bus.In = 4'd0; bus.Ready = 1'b0;
    test_reset();
    test_clean_press();
    test_backpressure();
    test_glitch();
    test_multi();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
